// File: rtl/clock_pkg.sv
// clock_pkg: shared types and BCD limits for the time-of-day keeper.
package clock_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2
  } mode_t;

  localparam logic [7:0] SEC_MAX  = 8'h59;
  localparam logic [7:0] MIN_MAX  = 8'h59;
  localparam logic [7:0] HR24_MAX = 8'h23;
  localparam logic [7:0] HR12_MAX = 8'h12;
  localparam logic [7:0] HR12_MIN = 8'h01;

endpackage

// File: rtl/sync_rise.sv
// sync_rise: multi-flop level synchroniser followed by a rising-edge detector.
// q_lvl is the last synchroniser stage; q_rise is high for one clkM cycle
// after q_lvl goes 0->1, so the registered consumer acts STAGES+1 edges
// after the input rises.
module sync_rise #(
  parameter int STAGES = 2
) (
  input  logic clkM,
  input  logic clr,
  input  logic d_in,
  output logic q_lvl,
  output logic q_rise
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // shift the async level through the synchroniser and remember last level
  always_ff @(posedge clkM or negedge clr) begin
    if (!clr) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_in};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q_lvl  = sync_q[STAGES-1];
  assign q_rise = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/time_keeper.sv
// time_keeper: BCD HH:MM:SS time-of-day counter driven by the divider's 1 s and
// 2 s square waves, with a button-driven hour/minute setting mode.
// Optional build macro CLK12_MODE_EN selects 12-hour operation with a PM flag;
// without it the counter runs 00-23 and pm is held at 0.
//
// state   | meaning
// RUN     | seconds advance on each 1 s tick, carries ripple into min/hr
// SET_HR  | seconds frozen, hour steps on 2 s tick while inc is held
// SET_MIN | minute steps on 2 s tick while inc is held; exit clears seconds
module time_keeper
  import clock_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] HR_INIT     = 8'h00,
  parameter logic [7:0] MIN_INIT    = 8'h00
) (
  input  logic       clkM,
  input  logic       clr,
  input  logic       clk1_in,
  input  logic       clk2_in,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [7:0] sec_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] hr_bcd,
  output logic [1:0] mode,
  output logic       blink,
  output logic       sec_tick,
  output logic       pm
);

`ifdef CLK12_MODE_EN
  localparam logic [7:0] HR_RST = HR12_MAX;
`else
  localparam logic [7:0] HR_RST = HR_INIT;
`endif

  logic t1, t2, pm_edge, clk2_lvl, inc_lvl;
  logic clk1_lvl, mode_lvl, inc_rise;
  logic unused_sync;

  sync_rise #(.STAGES(SYNC_STAGES)) u_sync_clk1 (
    .clkM(clkM), .clr(clr), .d_in(clk1_in), .q_lvl(clk1_lvl), .q_rise(t1));
  sync_rise #(.STAGES(SYNC_STAGES)) u_sync_clk2 (
    .clkM(clkM), .clr(clr), .d_in(clk2_in), .q_lvl(clk2_lvl), .q_rise(t2));
  sync_rise #(.STAGES(SYNC_STAGES)) u_sync_mode (
    .clkM(clkM), .clr(clr), .d_in(btn_mode), .q_lvl(mode_lvl), .q_rise(pm_edge));
  sync_rise #(.STAGES(SYNC_STAGES)) u_sync_inc (
    .clkM(clkM), .clr(clr), .d_in(btn_inc), .q_lvl(inc_lvl), .q_rise(inc_rise));

  assign unused_sync = clk1_lvl ^ mode_lvl ^ inc_rise;

  // one BCD step: wrap to 'wrap' at 'lim', otherwise units roll into tens
  function automatic logic [7:0] bcd_inc(input logic [7:0] v,
                                         input logic [7:0] lim,
                                         input logic [7:0] wrap);
    logic [7:0] r;
    if (v == lim)              r = wrap;
    else if (v[3:0] == 4'd9)   r = {v[7:4] + 4'd1, 4'd0};
    else                       r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  mode_t      mode_q, mode_d;
  logic [7:0] sec_q, sec_d, min_q, min_d, hr_q, hr_d;
  logic       pm_q, pm_d, tick_q, tick_d, blink_q, blink_d;
  logic [7:0] hr_inc;
  logic       pm_inc;

  // hour successor shared by the RUN carry and SET_HR stepping
  always_comb begin
`ifdef CLK12_MODE_EN
    hr_inc = bcd_inc(hr_q, HR12_MAX, HR12_MIN);
    pm_inc = pm_q ^ (hr_q == 8'h11);
`else
    hr_inc = bcd_inc(hr_q, HR24_MAX, 8'h00);
    pm_inc = 1'b0;
`endif
  end

  // next-state: mode sequencing and counter updates, ticks use the current mode
  always_comb begin
    mode_d = mode_q;
    sec_d  = sec_q;
    min_d  = min_q;
    hr_d   = hr_q;
    pm_d   = pm_q;
    tick_d = 1'b0;
    unique case (mode_q)
      RUN: begin
        if (t1) begin
          tick_d = 1'b1;
          sec_d  = bcd_inc(sec_q, SEC_MAX, 8'h00);
          if (sec_q == SEC_MAX) begin
            min_d = bcd_inc(min_q, MIN_MAX, 8'h00);
            if (min_q == MIN_MAX) begin
              hr_d = hr_inc;
              pm_d = pm_inc;
            end
          end
        end
        if (pm_edge) mode_d = SET_HR;
      end
      SET_HR: begin
        if (t2 && inc_lvl) begin
          hr_d = hr_inc;
          pm_d = pm_inc;
        end
        if (pm_edge) mode_d = SET_MIN;
      end
      SET_MIN: begin
        if (t2 && inc_lvl) min_d = bcd_inc(min_q, MIN_MAX, 8'h00);
        if (pm_edge) begin
          mode_d = RUN;
          sec_d  = 8'h00;
        end
      end
      default: mode_d = RUN;
    endcase
    blink_d = (mode_d != RUN) & clk2_lvl;
  end

  // state and output registers
  always_ff @(posedge clkM or negedge clr) begin
    if (!clr) begin
      mode_q  <= RUN;
      sec_q   <= 8'h00;
      min_q   <= MIN_INIT;
      hr_q    <= HR_RST;
      pm_q    <= 1'b0;
      tick_q  <= 1'b0;
      blink_q <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hr_q    <= hr_d;
      pm_q    <= pm_d;
      tick_q  <= tick_d;
      blink_q <= blink_d;
    end
  end

  assign sec_bcd  = sec_q;
  assign min_bcd  = min_q;
  assign hr_bcd   = hr_q;
  assign mode     = mode_q;
  assign blink    = blink_q;
  assign sec_tick = tick_q;
  assign pm       = pm_q;

endmodule

// File: tb/tb_time_keeper.sv
// tb_time_keeper: directed plus randomised events against a time-of-day model
// kept as plain integers (hours, minutes, seconds, mode index).
module tb_time_keeper;

  localparam int S = 2;

  logic       clkM, clr, clk1_in, clk2_in, btn_mode, btn_inc;
  logic [7:0] sec_bcd, min_bcd, hr_bcd;
  logic [1:0] mode;
  logic       blink, sec_tick, pm;

  time_keeper #(.SYNC_STAGES(S), .HR_INIT(8'h00), .MIN_INIT(8'h00)) dut (
    .clkM(clkM), .clr(clr), .clk1_in(clk1_in), .clk2_in(clk2_in),
    .btn_mode(btn_mode), .btn_inc(btn_inc), .sec_bcd(sec_bcd),
    .min_bcd(min_bcd), .hr_bcd(hr_bcd), .mode(mode), .blink(blink),
    .sec_tick(sec_tick), .pm(pm));

  initial clkM = 1'b0;
  always #5 clkM = ~clkM;

  int h, m, s, md;
  bit pm_m, inc_m;
  int n_pass = 0;
  int n_total = 0;

  function automatic logic [7:0] bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  function automatic void model_reset();
`ifdef CLK12_MODE_EN
    h = 12;
`else
    h = 0;
`endif
    m = 0; s = 0; md = 0; pm_m = 1'b0;
  endfunction

  function automatic void hr_adv();
`ifdef CLK12_MODE_EN
    if (h == 11) begin h = 12; pm_m = ~pm_m; end
    else if (h == 12) h = 1;
    else h = h + 1;
`else
    h = (h + 1) % 24;
`endif
  endfunction

  function automatic void sec_adv();
    s = s + 1;
    if (s == 60) begin
      s = 0; m = m + 1;
      if (m == 60) begin m = 0; hr_adv(); end
    end
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_all(input bit tk, input bit bl);
    chk("sec",      sec_bcd, bcd(s));
    chk("min",      min_bcd, bcd(m));
    chk("hr",       hr_bcd,  bcd(h));
    chk("mode",     {6'b0, mode}, 8'(md));
    chk("sec_tick", {7'b0, sec_tick}, {7'b0, tk});
    chk("blink",    {7'b0, blink}, {7'b0, bl});
    chk("pm",       {7'b0, pm}, {7'b0, pm_m});
  endtask

  task automatic set_inc(input bit v);
    btn_inc = v;
    repeat (S + 1) @(posedge clkM);
    #1;
    inc_m = v;
  endtask

  // one event: raise the selected inputs, check latency and result, release
  task automatic ev(input bit c1, input bit c2, input bit mb);
    bit tk, bl;
    @(posedge clkM); #1;
    if (c1) clk1_in = 1'b1;
    if (c2) clk2_in = 1'b1;
    if (mb) btn_mode = 1'b1;
    repeat (S) @(posedge clkM);
    #1;
    chk("pre_tick", {7'b0, sec_tick}, 8'h00);
    chk("pre_mode", {6'b0, mode}, 8'(md));
    @(posedge clkM); #1;
    tk = 1'b0;
    if (c1 && md == 0) begin tk = 1'b1; sec_adv(); end
    if (c2 && inc_m) begin
      if (md == 1) hr_adv();
      else if (md == 2) m = (m + 1) % 60;
    end
    if (mb) begin
      if (md == 2) s = 0;
      md = (md + 1) % 3;
    end
    bl = c2 && (md != 0);
    check_all(tk, bl);
    clk1_in = 1'b0; clk2_in = 1'b0; btn_mode = 1'b0;
    repeat (S + 2) @(posedge clkM);
    #1;
    check_all(1'b0, 1'b0);
  endtask

  task automatic set_time(input int th, input int tm);
    set_inc(1'b1);
    ev(0, 0, 1);
    for (int i = 0; i < 30 && h != th; i++) ev(0, 1, 0);
    ev(0, 0, 1);
    for (int i = 0; i < 70 && m != tm; i++) ev(0, 1, 0);
    ev(0, 0, 1);
  endtask

  initial begin
    clr = 1'b1; clk1_in = 1'b0; clk2_in = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
    inc_m = 1'b0;
    #2 clr = 1'b0;
    model_reset();
    repeat (3) @(posedge clkM);
    #1;
    check_all(1'b0, 1'b0);
    clr = 1'b1;
    repeat (2) @(posedge clkM);
    #1;

    // first second after reset: latency and value
    ev(1, 0, 0);

    // full rollover from 23:59:59
    set_time(23, 59);
    for (int i = 0; i < 70 && s != 59; i++) ev(1, 0, 0);
    ev(1, 0, 0);
    repeat (3) ev(1, 0, 0);

    // hour setting from 22 across the wrap, 1 s ticks ignored
    ev(0, 0, 1);
    for (int i = 0; i < 30 && h != 22; i++) ev(0, 1, 0);
    repeat (3) ev(0, 1, 0);
    ev(1, 0, 0);
    set_inc(1'b0);
    ev(0, 1, 0);
    set_inc(1'b1);

    // minute setting from 58 across the wrap, then exit clears seconds
    ev(0, 0, 1);
    for (int i = 0; i < 70 && m != 58; i++) ev(0, 1, 0);
    repeat (2) ev(0, 1, 0);
    ev(1, 0, 0);
    ev(0, 0, 1);

    // mode edge coincident with a seconds tick
    repeat (2) ev(1, 0, 0);
    ev(1, 0, 1);
    ev(0, 0, 1);
    ev(0, 0, 1);

`ifdef CLK12_MODE_EN
    set_time(11, 59);
    for (int i = 0; i < 70 && s != 59; i++) ev(1, 0, 0);
    ev(1, 0, 0);
    chk("pm_at_noon", {7'b0, pm}, 8'h01);
    ev(0, 0, 1);
    ev(0, 1, 0);
    ev(0, 0, 1);
    ev(0, 0, 1);
`endif

    // randomised mix
    for (int i = 0; i < 120; i++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: ev(1, 0, 0);
        3: begin
          if (1'($urandom_range(0, 1)) != inc_m) set_inc(~inc_m);
          ev(0, 1, 0);
        end
        4: ev(0, 0, 1);
        default: ev(1, 0, 1);
      endcase
    end

    // asynchronous reset while setting
    set_inc(1'b1);
    for (int i = 0; i < 3 && md == 0; i++) ev(0, 0, 1);
    ev(0, 1, 0);
    #2 clr = 1'b0;
    #1;
    model_reset();
    check_all(1'b0, 1'b0);
    btn_inc = 1'b0;
    inc_m = 1'b0;
    @(posedge clkM); #1;
    clr = 1'b1;
    repeat (2) @(posedge clkM);
    #1;
    ev(1, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
